// File: rtl/compositor_pkg.sv
// Shared types and helpers for the layer compositor: fade FSM state encoding,
// the default colour key and packed {R,G,B} channel split/join helpers.
package compositor_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_OUT = 2'd1,
      BLACK    = 2'd2,
      FADE_IN  = 2'd3
   } fade_state_t;

   // Colour that drawers present when they have nothing to show.
   localparam logic [7:0] DEF_TRANSPARENT = 8'hFF;

   // Extract a w-bit channel starting at bit lsb from a packed colour.
   function automatic int unsigned rgb_chan(input int unsigned rgb,
                                            input int unsigned lsb,
                                            input int unsigned w);
      return (rgb >> lsb) & ((32'd1 << w) - 32'd1);
   endfunction

   // Rebuild a packed {R,G,B} colour from its channels.
   function automatic int unsigned rgb_pack(input int unsigned r,
                                            input int unsigned g,
                                            input int unsigned b,
                                            input int unsigned g_w,
                                            input int unsigned b_w);
      return (r << (g_w + b_w)) | (g << b_w) | b;
   endfunction

endpackage

// File: rtl/layer_compositor_fade_ctrl.sv
// Whole-screen fade engine: walks a brightness level between FADE_STEPS
// (full) and 0 (black), changing it only at frame starts so a frame is never
// drawn with two different levels.
module fade_ctrl
   import compositor_pkg::*;
#(
   parameter int FADE_STEPS      = 8,
   parameter int FRAMES_PER_STEP = 4,
   parameter int LVL_W           = $clog2(FADE_STEPS) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_of_frame,
   input  logic             fade_req,
   input  logic             fade_dir,
   output logic [LVL_W-1:0] level,
   output logic             fade_busy,
   output logic             fade_done,
   output logic [1:0]       fade_state
);

   localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(FADE_STEPS);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

   fade_state_t       state_q, state_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [STEP_W-1:0] step_q,  step_d;
   logic              done_q,  done_d;

   // Next-state logic. A taken request always wins over a coincident frame
   // start, so that frame start never counts toward the first step.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      step_d  = step_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            level_d = LVL_MAX;
            if (fade_req && fade_dir) begin
               state_d = FADE_OUT;
               step_d  = '0;
            end
         end
         BLACK: begin
            level_d = '0;
            if (fade_req && !fade_dir) begin
               state_d = FADE_IN;
               step_d  = '0;
            end
         end
         FADE_OUT: begin
            if (fade_req && !fade_dir) begin
               state_d = FADE_IN;
               step_d  = '0;
            end else if (start_of_frame) begin
               if (step_q == STEP_LAST) begin
                  step_d = '0;
                  if (level_q <= LVL_W'(1)) begin
                     level_d = '0;
                     state_d = BLACK;
                     done_d  = 1'b1;
                  end else begin
                     level_d = level_q - LVL_W'(1);
                  end
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end
         FADE_IN: begin
            if (fade_req && fade_dir) begin
               state_d = FADE_OUT;
               step_d  = '0;
            end else if (start_of_frame) begin
               if (step_q == STEP_LAST) begin
                  step_d = '0;
                  if (level_q >= LVL_MAX - LVL_W'(1)) begin
                     level_d = LVL_MAX;
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     level_d = level_q + LVL_W'(1);
                  end
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, level, step and done registers; reset means full brightness.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         level_q <= LVL_MAX;
         step_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         step_q  <= step_d;
         done_q  <= done_d;
      end
   end

   assign level      = level_q;
   assign fade_busy  = (state_q == FADE_OUT) || (state_q == FADE_IN);
   assign fade_done  = done_q;
   assign fade_state = state_q;

endmodule

// File: rtl/layer_compositor.sv
// Composites LAYERS drawing requests over a background in a two-stage
// pipeline: stage 1 resolves priority (with enable, colour key and flashing),
// stage 2 applies the global fade level to each colour channel.
module layer_compositor
   import compositor_pkg::*;
#(
   parameter int LAYERS          = 8,
   parameter int R_W             = 3,
   parameter int G_W             = 3,
   parameter int B_W             = 2,
   parameter logic [R_W+G_W+B_W-1:0] TRANSPARENT = (R_W+G_W+B_W)'(DEF_TRANSPARENT),
   parameter int FLASH_PERIOD    = 16,
   parameter int FADE_STEPS      = 8,
   parameter int FRAMES_PER_STEP = 4,
   parameter int RGB_W           = R_W + G_W + B_W,
   parameter int IDX_W           = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pixel_valid,
   input  logic                    start_of_frame,
   input  logic [LAYERS-1:0]       layer_dr,
   input  logic [LAYERS*RGB_W-1:0] layer_rgb,
   input  logic [LAYERS-1:0]       layer_en,
   input  logic [LAYERS-1:0]       flash_mask,
   input  logic [RGB_W-1:0]        bg_rgb,
   input  logic                    fade_req,
   input  logic                    fade_dir,
   output logic [RGB_W-1:0]        rgb,
   output logic                    rgb_valid,
   output logic [IDX_W-1:0]        top_layer,
   output logic                    hit,
   output logic                    fade_busy,
   output logic                    fade_done,
   output logic [1:0]              fade_state
);

   localparam int LVL_W = $clog2(FADE_STEPS) + 1;
   localparam int SHIFT = $clog2(FADE_STEPS);
   localparam int FL_W  = $clog2(FLASH_PERIOD);

   logic [LVL_W-1:0] level;

   fade_ctrl #(
      .FADE_STEPS      (FADE_STEPS),
      .FRAMES_PER_STEP (FRAMES_PER_STEP),
      .LVL_W           (LVL_W)
   ) u_fade (
      .clk            (clk),
      .reset          (reset),
      .start_of_frame (start_of_frame),
      .fade_req       (fade_req),
      .fade_dir       (fade_dir),
      .level          (level),
      .fade_busy      (fade_busy),
      .fade_done      (fade_done),
      .fade_state     (fade_state)
   );

   // ---------------- flash counter ----------------
   logic [FL_W-1:0] flash_cnt_q, flash_cnt_d;
   logic            flash_off;

   // Advance the flash phase once per frame, wrapping at FLASH_PERIOD.
   always_comb begin
      flash_cnt_d = flash_cnt_q;
      if (start_of_frame) begin
         flash_cnt_d = (flash_cnt_q == FL_W'(FLASH_PERIOD - 1)) ? '0
                                                                : flash_cnt_q + FL_W'(1);
      end
   end

   // Flash phase register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) flash_cnt_q <= '0;
      else       flash_cnt_q <= flash_cnt_d;
   end

   // Second half of each flash period hides the masked layers.
   assign flash_off = (flash_cnt_q >= FL_W'(FLASH_PERIOD / 2));

   // ---------------- stage 1: priority resolve ----------------
   logic [RGB_W-1:0] win_rgb, lrgb;
   logic [IDX_W-1:0] win_idx;
   logic             win_hit;

   // Scan from the lowest priority upwards so the lowest qualifying index is
   // the last one written and therefore wins.
   always_comb begin
      win_rgb = bg_rgb;
      win_idx = '0;
      win_hit = 1'b0;
      lrgb    = '0;
      for (int i = LAYERS - 1; i >= 0; i--) begin
         lrgb = layer_rgb[i*RGB_W +: RGB_W];
         if (layer_dr[i] && layer_en[i] && (lrgb != TRANSPARENT) &&
             !(flash_mask[i] && flash_off)) begin
            win_rgb = lrgb;
            win_idx = IDX_W'(i);
            win_hit = 1'b1;
         end
      end
   end

   logic [RGB_W-1:0] s1_rgb_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic             s1_hit_q, s1_vld_q;

   // Stage 1 register loads every cycle; pixel_valid only rides along.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_rgb_q <= '0;
         s1_idx_q <= '0;
         s1_hit_q <= 1'b0;
         s1_vld_q <= 1'b0;
      end else begin
         s1_rgb_q <= win_rgb;
         s1_idx_q <= win_idx;
         s1_hit_q <= win_hit;
         s1_vld_q <= pixel_valid;
      end
   end

   // ---------------- stage 2: fade scaling ----------------
   logic [R_W-1:0]       r_in;
   logic [G_W-1:0]       g_in;
   logic [B_W-1:0]       b_in;
   logic [R_W+LVL_W-1:0] r_prod;
   logic [G_W+LVL_W-1:0] g_prod;
   logic [B_W+LVL_W-1:0] b_prod;
   logic [RGB_W-1:0]     scaled;

   // Each channel is multiplied at full width, then divided by FADE_STEPS.
   always_comb begin
      r_in   = R_W'(rgb_chan(32'(s1_rgb_q), G_W + B_W, R_W));
      g_in   = G_W'(rgb_chan(32'(s1_rgb_q), B_W, G_W));
      b_in   = B_W'(rgb_chan(32'(s1_rgb_q), 0, B_W));
      r_prod = (R_W+LVL_W)'(r_in) * (R_W+LVL_W)'(level);
      g_prod = (G_W+LVL_W)'(g_in) * (G_W+LVL_W)'(level);
      b_prod = (B_W+LVL_W)'(b_in) * (B_W+LVL_W)'(level);
      scaled = RGB_W'(rgb_pack(32'(R_W'(r_prod >> SHIFT)),
                               32'(G_W'(g_prod >> SHIFT)),
                               32'(B_W'(b_prod >> SHIFT)),
                               G_W, B_W));
   end

   logic [RGB_W-1:0] rgb_q;
   logic [IDX_W-1:0] top_q;
   logic             hit_q, vld_q;

   // Output register; reset clears the visible pixel immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb_q <= '0;
         top_q <= '0;
         hit_q <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         rgb_q <= scaled;
         top_q <= s1_idx_q;
         hit_q <= s1_hit_q;
         vld_q <= s1_vld_q;
      end
   end

   assign rgb       = rgb_q;
   assign top_layer = top_q;
   assign hit       = hit_q;
   assign rgb_valid = vld_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: reset values, a vector table for priority,
// colour key and enable, random pixels against a reference model, flashing,
// and fade sequences including reversal, ignored requests and reset mid-fade.
`timescale 1ns/1ps
module tb_layer_compositor;

   localparam int LAYERS = 8;
   localparam int FPS    = 4;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        pixel_valid, start_of_frame, fade_req, fade_dir;
   logic [7:0]  layer_dr, layer_en, flash_mask, bg_rgb;
   logic [63:0] layer_rgb;
   logic [7:0]  rgb;
   logic        rgb_valid, hit, fade_busy, fade_done;
   logic [2:0]  top_layer;
   logic [1:0]  fade_state;

   always #5 clk = ~clk;

   layer_compositor dut (
      .clk            (clk),
      .reset          (reset),
      .pixel_valid    (pixel_valid),
      .start_of_frame (start_of_frame),
      .layer_dr       (layer_dr),
      .layer_rgb      (layer_rgb),
      .layer_en       (layer_en),
      .flash_mask     (flash_mask),
      .bg_rgb         (bg_rgb),
      .fade_req       (fade_req),
      .fade_dir       (fade_dir),
      .rgb            (rgb),
      .rgb_valid      (rgb_valid),
      .top_layer      (top_layer),
      .hit            (hit),
      .fade_busy      (fade_busy),
      .fade_done      (fade_done),
      .fade_state     (fade_state)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   always @(negedge clk) if (fade_done === 1'b1) done_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] scale(input logic [7:0] c, input int lvl);
      int r, g, b;
      r = int'(c[7:5]) * lvl / 8;
      g = int'(c[4:2]) * lvl / 8;
      b = int'(c[1:0]) * lvl / 8;
      return {r[2:0], g[2:0], b[1:0]};
   endfunction

   // Returns {valid, hit, top_layer, rgb}.
   function automatic logic [12:0] ref_pix(input logic [7:0] dr, input logic [7:0] en,
                                           input logic [7:0] fm, input logic [63:0] rgbs,
                                           input logic [7:0] bg, input bit foff,
                                           input int lvl, input bit pv);
      logic [7:0] c, li;
      int         idx;
      bit         h;
      c = bg; idx = 0; h = 0;
      for (int i = 0; i < LAYERS; i++) begin
         li = rgbs[i*8 +: 8];
         if (!h && dr[i] && en[i] && li != 8'hFF && !(fm[i] && foff)) begin
            c = li; idx = i; h = 1;
         end
      end
      return {pv, h, 3'(idx), scale(c, lvl)};
   endfunction

   // Fade model: current level, direction of travel and frames into the step.
   int m_level = 8;
   int m_dir   = 0;
   int m_cnt   = 0;
   int m_done  = 0;

   function automatic logic [1:0] exp_state();
      if (m_dir < 0) return 2'd1;
      if (m_dir > 0) return 2'd3;
      return (m_level == 0) ? 2'd2 : 2'd0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic rand_burst(input int n, input int lvl, input bit use_fm);
      logic [12:0] exp_q[$];
      logic [12:0] e;
      for (int k = 0; k < n + 2; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            e = exp_q.pop_front();
            check("rand_rgb",   32'(rgb),       32'(e[7:0]));
            check("rand_top",   32'(top_layer), 32'(e[10:8]));
            check("rand_hit",   32'(hit),       32'(e[11]));
            check("rand_valid", 32'(rgb_valid), 32'(e[12]));
         end
         if (k < n) begin
            pixel_valid = 1'($urandom_range(0, 1));
            layer_dr    = 8'($urandom);
            layer_en    = 8'($urandom) | 8'($urandom);
            flash_mask  = use_fm ? 8'($urandom) : 8'h00;
            bg_rgb      = 8'($urandom);
            for (int i = 0; i < LAYERS; i++)
               layer_rgb[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            exp_q.push_back(ref_pix(layer_dr, layer_en, flash_mask, layer_rgb,
                                    bg_rgb, 1'b0, lvl, pixel_valid));
         end
      end
   endtask

   task automatic pulse_sof();
      start_of_frame = 1'b1;
      @(negedge clk);
      start_of_frame = 1'b0;
   endtask

   // Flash check: frame number is counted from the last reset.
   task automatic flash_frames(input int n, input int first);
      logic [7:0] e;
      for (int f = 0; f < n; f++) begin
         repeat (3) @(negedge clk);
         e = (((first + f) % 16) < 8) ? 8'h1C : 8'h00;
         check("flash_rgb", 32'(rgb), 32'(e));
         pulse_sof();
      end
   endtask

   task automatic fade_cmd(input bit dir, input bit with_sof, input bit taken);
      fade_req       = 1'b1;
      fade_dir       = dir;
      start_of_frame = with_sof;
      @(negedge clk);
      fade_req       = 1'b0;
      start_of_frame = 1'b0;
      if (taken) begin
         m_dir = dir ? -1 : 1;
         m_cnt = 0;
      end
   endtask

   task automatic run_fade(input int n);
      for (int f = 0; f < n; f++) begin
         pulse_sof();
         if (m_dir != 0) begin
            m_cnt++;
            if (m_cnt == FPS) begin
               m_cnt   = 0;
               m_level = m_level + m_dir;
               if (m_level == 0 || m_level == 8) begin
                  m_dir = 0;
                  m_done++;
               end
            end
         end
         repeat (3) @(negedge clk);
         check("fade_rgb",   32'(rgb),        32'(scale(8'hFF, m_level)));
         check("fade_busy",  32'(fade_busy),  32'(m_dir != 0));
         check("fade_state", 32'(fade_state), 32'(exp_state()));
      end
      check("fade_done_cnt", 32'(done_cnt), 32'(m_done));
   endtask

   task automatic set_flat_bg();
      layer_dr   = 8'h00;
      layer_en   = 8'hFF;
      flash_mask = 8'h00;
      bg_rgb     = 8'hFF;
      pixel_valid = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]  dr;
      logic [7:0]  en;
      logic [63:0] rgbs;
      logic [7:0]  bg;
      logic [7:0]  e_rgb;
      logic [2:0]  e_top;
      logic        e_hit;
   } vec_t;

   vec_t vecs[7];

   // ---------------- main sequence ----------------
   initial begin
      vecs[0] = '{dr: 8'h0A, en: 8'hFF, rgbs: 64'h0000_0000_E000_1C00, bg: 8'h00,
                  e_rgb: 8'h1C, e_top: 3'd1, e_hit: 1'b1};
      vecs[1] = '{dr: 8'h08, en: 8'hFF, rgbs: 64'h0000_0000_E000_1C00, bg: 8'h00,
                  e_rgb: 8'hE0, e_top: 3'd3, e_hit: 1'b1};
      vecs[2] = '{dr: 8'h05, en: 8'hFF, rgbs: 64'h0000_0000_0003_00FF, bg: 8'h00,
                  e_rgb: 8'h03, e_top: 3'd2, e_hit: 1'b1};
      vecs[3] = '{dr: 8'h05, en: 8'hFB, rgbs: 64'h0000_0000_0003_00FF, bg: 8'h49,
                  e_rgb: 8'h49, e_top: 3'd0, e_hit: 1'b0};
      vecs[4] = '{dr: 8'h00, en: 8'hFF, rgbs: 64'h1122_3344_5566_7788, bg: 8'h5A,
                  e_rgb: 8'h5A, e_top: 3'd0, e_hit: 1'b0};
      vecs[5] = '{dr: 8'hFF, en: 8'hFF, rgbs: 64'h12FF_FFFF_FFFF_FFFF, bg: 8'h00,
                  e_rgb: 8'h12, e_top: 3'd7, e_hit: 1'b1};
      vecs[6] = '{dr: 8'hFF, en: 8'h24, rgbs: 64'h5511_2233_4455_6677, bg: 8'h00,
                  e_rgb: 8'h55, e_top: 3'd2, e_hit: 1'b1};

      reset = 1'b1;
      pixel_valid = 1'b1; start_of_frame = 1'b0; fade_req = 1'b0; fade_dir = 1'b0;
      layer_dr = 8'h00; layer_en = 8'hFF; flash_mask = 8'h00; bg_rgb = 8'h00;
      layer_rgb = '0;
      #1;
      check("rst_rgb",       32'(rgb),        32'h0);
      check("rst_valid",     32'(rgb_valid),  32'h0);
      check("rst_top",       32'(top_layer),  32'h0);
      check("rst_hit",       32'(hit),        32'h0);
      check("rst_fade_busy", 32'(fade_busy),  32'h0);
      check("rst_fade_done", 32'(fade_done),  32'h0);
      check("rst_state",     32'(fade_state), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Priority, colour key and enable.
      for (int v = 0; v < 7; v++) begin
         layer_dr = vecs[v].dr; layer_en = vecs[v].en;
         layer_rgb = vecs[v].rgbs; bg_rgb = vecs[v].bg;
         repeat (2) @(negedge clk);
         check($sformatf("vec%0d_rgb", v),   32'(rgb),       32'(vecs[v].e_rgb));
         check($sformatf("vec%0d_top", v),   32'(top_layer), 32'(vecs[v].e_top));
         check($sformatf("vec%0d_hit", v),   32'(hit),       32'(vecs[v].e_hit));
         check($sformatf("vec%0d_valid", v), 32'(rgb_valid), 32'h1);
      end

      // Random pixels at full brightness, flash phase still on.
      rand_burst(200, 8, 1'b1);

      // Flashing layer 0 over black for two full flash periods.
      pixel_valid = 1'b1; layer_dr = 8'h01; layer_en = 8'hFF; flash_mask = 8'h01;
      bg_rgb = 8'h00; layer_rgb = 64'h0000_0000_0000_001C;
      flash_frames(32, 0);

      // Fade out; the request coincides with a frame start that must not count.
      set_flat_bg();
      @(negedge clk);
      fade_cmd(1'b1, 1'b1, 1'b1);
      run_fade(16);
      check("fade_level4_rgb", 32'(rgb), 32'h6D);
      run_fade(16);
      check("black_state", 32'(fade_state), 32'd2);

      // Fade-out request while black is ignored; then fade back in.
      fade_cmd(1'b1, 1'b0, 1'b0);
      run_fade(6);
      fade_cmd(1'b0, 1'b0, 1'b1);
      run_fade(32);

      // Fade-in request while idle is ignored.
      fade_cmd(1'b0, 1'b0, 1'b0);
      run_fade(5);

      // Fade out to level 5 with a same-direction request on the way.
      fade_cmd(1'b1, 1'b0, 1'b1);
      run_fade(2);
      fade_cmd(1'b1, 1'b0, 1'b0);
      run_fade(10);
      check("level5_rgb", 32'(rgb), 32'(scale(8'hFF, 5)));

      // Random pixels scaled at level 5 (no frame starts, so level holds).
      rand_burst(60, 5, 1'b0);
      set_flat_bg();

      // Reverse back to full brightness.
      fade_cmd(1'b0, 1'b0, 1'b1);
      run_fade(12);
      check("reversal_idle_state", 32'(fade_state), 32'd0);

      // Reset in the middle of a fade at level 3.
      fade_cmd(1'b1, 1'b0, 1'b1);
      run_fade(20);
      check("pre_reset_rgb", 32'(rgb), 32'(scale(8'hFF, 3)));
      #2 reset = 1'b1;
      #1;
      check("midrst_rgb",   32'(rgb),       32'h0);
      check("midrst_valid", 32'(rgb_valid), 32'h0);
      check("midrst_busy",  32'(fade_busy), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      m_level = 8; m_dir = 0; m_cnt = 0;
      repeat (2) @(negedge clk);
      check("post_rst_rgb",   32'(rgb),        32'hFF);
      check("post_rst_busy",  32'(fade_busy),  32'h0);
      check("post_rst_state", 32'(fade_state), 32'h0);

      // Flash phase restarts from frame 0 after reset.
      layer_dr = 8'h01; flash_mask = 8'h01; bg_rgb = 8'h00;
      layer_rgb = 64'h0000_0000_0000_001C;
      flash_frames(18, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Time limit so the run always ends on its own.
   initial begin
      #1_000_000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: time limit reached, got timeout expected finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
Parametrised successor to the fixed-count settings priority mux. It composites LAYERS drawing requests onto a background through a registered two-stage pipeline. Beyond plain priority, it adds per-layer enable, a transparent colour key, frame-synchronous layer flashing, and a whole-screen fade-out/fade-in engine. It sits between the object drawers and the VGA output for any screen (game, settings, menus).

Parameters:
LAYERS, 8, number of drawer inputs; index 0 has the highest priority
R_W, 3, red channel width
G_W, 3, green channel width
B_W, 2, blue channel width (RGB_W = R_W+G_W+B_W, packed {R,G,B})
TRANSPARENT, 8'hFF, colour key treated as "not drawing"
FLASH_PERIOD, 16, frames per flash cycle (even, >=2)
FADE_STEPS, 8, fade levels, power of 2
FRAMES_PER_STEP, 4, frames between fade level changes (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pixel_valid  in  1  current pixel inputs are valid
start_of_frame  in  1  one-cycle pulse at frame start
layer_dr  in  LAYERS  per-layer drawing request
layer_rgb  in  LAYERS x RGB_W  per-layer colour
layer_en  in  LAYERS  per-layer enable (static config)
flash_mask  in  LAYERS  layers subject to flashing
bg_rgb  in  RGB_W  background colour
fade_req  in  1  one-cycle fade command
fade_dir  in  1  1 = fade out (to black), 0 = fade in
rgb  out  RGB_W  composited colour
rgb_valid  out  1  pixel_valid delayed by 2
top_layer  out  $clog2(LAYERS)  winning layer index (0 if none)
hit  out  1  some layer won this pixel
fade_busy  out  1  fade FSM is in FADE_OUT or FADE_IN
fade_done  out  1  one-cycle pulse when a fade reaches its endpoint

Behaviour:
- Reset values: rgb=0, rgb_valid=0, top_layer=0, hit=0, fade_busy=0, fade_done=0. Internal state: fade state=IDLE, level=FADE_STEPS, flash counter=0, step counter=0.
- A layer qualifies when layer_dr[i] & layer_en[i] & layer_rgb[i]!=TRANSPARENT & !(flash_mask[i] & flash_off).
- Stage 1 (register): the lowest qualifying index wins. It registers the colour, index and hit. With no winner: colour=bg_rgb, index=0, hit=0.
- Stage 2 (register): each channel becomes (c*level)>>log2(FADE_STEPS), computed at full product width and then truncated. At level=FADE_STEPS the pixel passes unchanged; at level=0 it is black. top_layer and hit are delayed alongside the colour.
- Pipeline registers load every cycle regardless of pixel_valid. rgb_valid is pixel_valid delayed 2 cycles. Latency from input to rgb is exactly 2 cycles.
- Flash counter:
  - Increments mod FLASH_PERIOD on start_of_frame.
  - flash_off = (counter >= FLASH_PERIOD/2).
  - It changes only at frame boundaries.
- Fade FSM states and transitions (level changes only on start_of_frame, so there is no mid-frame tearing):
  - IDLE: level=FADE_STEPS. fade_req with dir=1 goes to FADE_OUT. fade_req with dir=0 is ignored.
  - FADE_OUT: the step counter counts start_of_frame pulses. Every FRAMES_PER_STEP frames, level decrements. When level reaches 0, go to BLACK and pulse fade_done.
  - BLACK: level=0. fade_req with dir=0 goes to FADE_IN. fade_req with dir=1 is ignored.
  - FADE_IN: mirror of FADE_OUT, incrementing level. When level reaches FADE_STEPS, go to IDLE and pulse fade_done.
  - Reversal: fade_req in the opposite direction during a fade switches to the other fading state. Level is kept, and the step counter clears.
  - Same-direction fade_req while fading is ignored.
- Entering a fading state clears the step counter.
- fade_req on the same cycle as start_of_frame: the request is taken and that start_of_frame does not count toward a step.
- fade_done rises on the cycle after the final start_of_frame.
- Reset asserted mid-fade returns immediately to IDLE at full brightness; the pipeline output becomes 0.

Decomposition:
- Shared package compositor_pkg holds:
  - fade_state_t enum {IDLE, FADE_OUT, BLACK, FADE_IN}
  - the RGB channel-split helper functions
  - default TRANSPARENT
- One natural sub-module: fade_ctrl, containing the FSM, the level and step counters, and the fade_busy/fade_done outputs. It outputs level to the top.
- Priority resolve and flash counter stay in the top module.

Test Plan:
1. Priority: layers 1 and 3 drawing with colours 8'h1C and 8'hE0 -> after 2 cycles rgb=8'h1C, top_layer=1, hit=1. Then drop layer 1 -> rgb=8'hE0, top_layer=3.
2. Transparency and enable:
   - Layer 0 drawing 8'hFF over layer 2 drawing 8'h03 -> rgb=8'h03.
   - Clear layer_en[2] with bg=8'h49 -> rgb=8'h49, hit=0.
3. Flash: flash_mask[0]=1, layer 0 drawing 8'h1C over bg 8'h00, 16 frames -> rgb=8'h1C for frames 0-7 and 8'h00 for frames 8-15, then repeating.
4. Fade out:
   - fade_req dir=1, pixel 8'hFF, no layers -> level drops 8→0 over 32 frames.
   - At level 4: rgb = {3'd3,3'd3,2'd1} = 8'h6D.
   - fade_done pulses once; the FSM sits in BLACK.
5. Reversal and ignore:
   - Reverse at level 5 with dir=0 -> level rises back to 8 and fade_done pulses in IDLE.
   - fade_req dir=0 while IDLE -> no change.
6. Reset mid-fade at level 3 -> rgb=0 and rgb_valid=0 immediately. After release: full brightness, fade_busy=0, and the flash counter restarts at 0.
